// File: rtl/alu_pkg.sv
// Shared ALU encodings and the multicycle FSM types, imported by the decoder and the execution unit.
package alu_pkg;

  // ALU_ctrl encodings; the decoder drives these and alu_multicycle consumes them.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef enum logic [1:0] {SH_LL = 2'd0, SH_RL = 2'd1, SH_RA = 2'd2} shift_mode_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

  function automatic shift_mode_t shift_mode(input logic [3:0] code);
    case (code)
      ALU_SRL: return SH_RL;
      ALU_SRA: return SH_RA;
      default: return SH_LL;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative shifter: accumulator plus down-counter, one bit position per step.
// acc is the accumulator value after the current step, so the top can capture
// the final result on the same edge that performs the last shift.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  shift_mode_t      mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [CW-1:0]    load_cnt,
  output logic             last,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt;
  shift_mode_t      mode_q;

  // One-bit shift of the held accumulator; mode is latched at load time.
  always_comb begin
    acc = acc_q;
    case (mode_q)
      SH_LL:   acc = {acc_q[WIDTH-2:0], 1'b0};
      SH_RL:   acc = {1'b0, acc_q[WIDTH-1:1]};
      SH_RA:   acc = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: acc = acc_q;
    endcase
  end

  assign last = (cnt == CW'(1));

  // Load operand/amount on acceptance, then shift and count down per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      cnt    <= '0;
      mode_q <= SH_LL;
    end else if (load) begin
      acc_q  <= load_val;
      cnt    <= load_cnt;
      mode_q <= mode;
    end else if (step) begin
      acc_q  <= acc;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle execute unit: single-cycle logic/arith ops, iterative shifts,
// start/done handshake with busy stalling the pipeline during shifts.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALU_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_y;
  logic             sh_load, sh_step, sh_last;
  logic [WIDTH-1:0] sh_acc;
  logic             res_load;
  logic [WIDTH-1:0] res_nxt;

  assign shamt = src_b[SW-1:0];

  // Single-cycle datapath, evaluated on the live inputs at acceptance.
  always_comb begin
    alu_y = '0;
    case (ALU_ctrl)
      ALU_AND: alu_y = src_a & src_b;
      ALU_OR:  alu_y = src_a | src_b;
      ALU_ADD: alu_y = src_a + src_b;
      ALU_XOR: alu_y = src_a ^ src_b;
      ALU_SUB: alu_y = src_a - src_b;
      ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_y = '0;
    endcase
  end

  alu_shift_iter #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .step     (sh_step),
    .mode     (shift_mode(ALU_ctrl)),
    .load_val (src_a),
    .load_cnt (shamt),
    .last     (sh_last),
    .acc      (sh_acc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, shifter control and result-load selection.
  always_comb begin
    state_nxt = state;
    sh_load   = 1'b0;
    sh_step   = 1'b0;
    res_load  = 1'b0;
    res_nxt   = alu_y;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_shift(ALU_ctrl) && (shamt != '0)) begin
            sh_load   = 1'b1;
            state_nxt = SHIFT;
          end else begin
            res_load  = 1'b1;
            res_nxt   = is_shift(ALU_ctrl) ? src_a : alu_y;
            state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        sh_step = 1'b1;
        if (sh_last) begin
          res_load  = 1'b1;
          res_nxt   = sh_acc;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Result/zero only change on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b1;
    end else if (res_load) begin
      result <= res_nxt;
      zero   <= (res_nxt == '0);
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: expected result/latency queued at drive,
// compared when done pulses.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   ctrl = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, zero;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ALU_ctrl (ctrl),
    .src_a    (a),
    .src_b    (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero)
  );

  int n_chk = 0, n_fail = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [W-1:0] res;
    int unsigned  due;
    int unsigned  lat;
    string        tag;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int unsigned busy_run = 0;
  logic [W-1:0] held = '0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [4:0] s;
    s = y[4:0];
    case (c)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0011: return x ^ y;
      4'b0110: return x - y;
      4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: return x << s;
      4'b1001: return x >> s;
      4'b1010: return $signed(x) >>> s;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: busy run length, done scoreboard, result stability.
  always @(negedge clk) begin
    if (rst || !busy) busy_run = 0;
    else              busy_run++;
    if (rst) begin
      held = result;
    end else if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_res"}, result, e.res);
        check({e.tag, "_zero"}, zero, (e.res == '0));
        check({e.tag, "_lat"}, cyc, e.due);
        check({e.tag, "_busy"}, busy_run, e.lat);
      end
      held = result;
    end else begin
      check("result_stable", result, held);
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic drive_op(input logic [3:0] code, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [W-1:0] exp_res, input string tag);
    int unsigned lat;
    wait_idle();
    ctrl  = code;
    a     = aa;
    b     = bb;
    start = 1'b1;
    lat = ((code inside {4'b1000, 4'b1001, 4'b1010}) && bb[4:0] != 0) ? bb[4:0] + 1 : 1;
    sb.push_back('{exp_res, cyc + lat, lat, tag});
    @(negedge clk);
    start = 1'b0;
    ctrl  = 4'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  logic [3:0] codes [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111,
                             4'b1000, 4'b1001, 4'b1010, 4'b0100, 4'b0101, 4'b1111};

  initial begin
    logic [3:0]   c;
    logic [W-1:0] x, y;
    int           k;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    rst = 1'b0;

    drive_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, "add_ovf");
    drive_op(ALU_SUB, 32'd5, 32'd5, 32'h0, "sub_zero");
    drive_op(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, "slt_neg");
    drive_op(ALU_SLT, 32'h1, 32'hFFFF_FFFF, 32'h0, "slt_pos");
    drive_op(ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, "sra31");
    drive_op(ALU_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, "srl31");
    drive_op(ALU_SLL, 32'h1, 32'd0, 32'h1, "sll0");
    drive_op(ALU_SLL, 32'h1, 32'd4, 32'h10, "sll4");
    drive_op(4'b0101, 32'h1234, 32'h5678, 32'h0, "unknown");
    drive_op(ALU_AND, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200, "and");
    drive_op(ALU_OR,  32'hF0F0_0000, 32'h0000_00FF, 32'hF0F0_00FF, "or");
    drive_op(ALU_XOR, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5555_AAAA, "xor");

    // Start pulsed mid-shift must be ignored.
    drive_op(ALU_SRL, 32'hF000_0000, 32'd8, 32'h00F0_0000, "srl_ign");
    repeat (3) @(negedge clk);
    ctrl = ALU_ADD; a = 32'h1; b = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset mid-shift abandons the op.
    drive_op(ALU_SLL, 32'h3, 32'd20, 32'h0030_0000, "sll_abort");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_zero", zero, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    drive_op(ALU_SRA, 32'h8765_4321, 32'd4, 32'hF876_5432, "sra4_after_rst");

    for (int i = 0; i < 16; i++) begin
      c = codes[$urandom_range(0, 11)];
      x = $urandom;
      y = $urandom;
      if (c inside {4'b1000, 4'b1001, 4'b1010}) y = {27'($urandom), 5'($urandom_range(0, 12))};
      drive_op(c, x, y, model(c, x, y), $sformatf("rnd%0d", i));
    end

    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Sequential execution unit at the far end of the `ALU_ctrl` interface. It consumes the 4-bit control code produced by the ALU decoder together with two operands. It performs the operation under a start/done handshake. Logic ops and add/subtract complete in one cycle; shifts run iteratively at one bit position per cycle. It sits in the execute stage and stalls the pipeline through `busy` while a shift is in progress.

## Interface
- `WIDTH`, 32, operand/result width; shift amount field is `$clog2(WIDTH)` bits.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `ALU_ctrl`  in  4  operation code, sampled with `start`.
- `src_a`  in  WIDTH  operand A, sampled with `start`.
- `src_b`  in  WIDTH  operand B; for shifts only `src_b[$clog2(WIDTH)-1:0]` (shamt) is used.
- `busy`  out  1  high in every cycle the FSM is not IDLE.
- `done`  out  1  one-cycle pulse; `result`/`zero` are valid in this cycle.
- `result`  out  WIDTH  registered result; holds its value until the next `done`.
- `zero`  out  1  registered (`result`==0), updated together with `result`.

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT, 1000 SLL, 1001 SRL, 1010 SRA.
- Any other code produces result 0 and zero 1, and completes like a single-cycle op.
- ADD and SUB wrap modulo 2^WIDTH, with no carry or overflow output.
- SLT is a signed two's-complement compare; result is 1 or 0, zero-extended.
- FSM states and transitions:
  - IDLE: `start`=1 with a single-cycle op → DONE, and `result`/`zero` are loaded on the same edge.
  - IDLE: `start`=1 with a shift op and shamt=0 → DONE, result = `src_a`.
  - IDLE: `start`=1 with a shift op and shamt>0 → SHIFT; the accumulator is loaded with `src_a` and the counter with shamt.
  - SHIFT: each cycle shifts the accumulator by 1 bit and decrements the counter. SLL fills with 0, SRL fills with 0, SRA fills with the sign bit (MSB). The edge that shifts with counter=1 also loads `result`/`zero` and moves to DONE.
  - DONE: `done`=1 and `busy`=1; next edge → IDLE.
- `start` is ignored while `busy`=1: no queuing and no error.
- Operands and the code are captured at acceptance. Changes on the inputs afterwards have no effect on the op in flight.

## Timing
- Reset (asynchronous, applied immediately):
  - FSM goes to IDLE.
  - `busy`, `done` = 0; `result` = 0; `zero` = 1.
  - Accumulator and counter = 0.
  - An op in flight is abandoned, and no `done` is issued for it.
- Latency, with `start` accepted in cycle T:
  - Single-cycle op: `done` in T+1.
  - Shift by n>0: `busy` in T+1..T+n+1, `done` in T+n+1.
  - Shift by 0: `done` in T+1.
- Throughput: one accepted op per 2 cycles at best. A new `start` may be accepted in the cycle after `done`.
- `result` and `zero` change only on the edge that enters DONE. They are stable in every other cycle.
- Boundary: shamt = WIDTH-1 takes the maximum latency of WIDTH cycles. SRA of a negative value by WIDTH-1 gives all ones.

## Structure
- Shared package `alu_pkg` holds the `ALU_ctrl` encodings as named 4-bit localparams or an enum. The same package is imported by the ALU decoder so both ends agree on the codes.
- Also in `alu_pkg`: the FSM state typedef (IDLE, SHIFT, DONE).
- Single sub-module `alu_shift_iter` holds the accumulator, counter and one-bit shift step. It has inputs load/step/mode and outputs `last` and `acc`.
- The top level holds the FSM, the single-cycle combinational datapath and the result/zero registers.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → `done` at T+1, result 0x80000000, zero 0. SUB 5−5 → result 0, zero 1.
- SLT with A=0xFFFFFFFF (−1), B=0x00000001 → result 1. SLT with A=1, B=−1 → result 0.
- SRA of 0x80000000 with shamt 31 → `busy` for 32 cycles, `done` at T+32, result 0xFFFFFFFF. SRL of the same operands → result 0x00000001.
- SLL of 0x00000001 with shamt 0 → `done` at T+1, result 0x00000001. SLL with shamt 4 → `done` at T+5, result 0x00000010.
- Pulse `start` with new operands during a SHIFT → ignored; the original result is unchanged. `start` in the cycle after `done` → accepted.
- Assert `rst` mid-SHIFT → `busy` and `done` 0 and `result` 0 immediately. No `done` follows; the next op runs normally.
- Unknown code 0101 → `done` at T+1, result 0, zero 1.
